// File: rtl/ballot_controller.sv
// ballot_controller: arms one ballot per voter session, debounces the three
// candidate buttons and forwards one clean single-cycle vote pulse to the tally.
// Ports: clk/rst (async, active-high); i_voter_enable (rising edge arms);
//   i_candidate_1..3 (raw async buttons); i_voting_over (close-of-poll level);
//   o_vote_1..3, o_ack (vote pulse), o_ready (ballot armed), o_error
//   (multi-press pulse), o_timeout (armed ballot expired), o_closed (sticky),
//   o_voters (ballots committed, saturating).
// Optional feature: define BALLOT_TIMEOUT_EN to build the armed-ballot timeout.
module ballot_controller #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 64,
  parameter int CNT_W           = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_voter_enable,
  input  logic             i_candidate_1,
  input  logic             i_candidate_2,
  input  logic             i_candidate_3,
  input  logic             i_voting_over,
  output logic             o_vote_1,
  output logic             o_vote_2,
  output logic             o_vote_3,
  output logic             o_ready,
  output logic             o_ack,
  output logic             o_error,
  output logic             o_timeout,
  output logic             o_closed,
  output logic [CNT_W-1:0] o_voters
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DEBOUNCE,
    S_COMMIT,
    S_WAIT_RELEASE,
    S_CLOSED
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic             r_en_q;
  logic             r_en_qq;
  logic             r_over_q;
  logic [2:0]       r_sel;
  logic [DB_W-1:0]  r_db_cnt;
  logic             r_err_lock;
  logic [2:0]       r_vote;
  logic             r_ack;
  logic             r_ready;
  logic             r_error;
  logic             r_closed;
  logic [CNT_W-1:0] r_voters;

  logic             w_en_rise;
  logic [1:0]       w_n_high;
  logic             w_one;
  logic             w_multi;
  logic             w_latch;
  logic             w_db_inc;
  logic             w_err;

`ifdef BALLOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_timeout;
  logic             w_to;
  logic             w_to_inc;
`else
  logic             w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  assign w_en_rise = r_en_q & ~r_en_qq;
  assign w_n_high  = {1'b0, r_sync2[0]} + {1'b0, r_sync2[1]} + {1'b0, r_sync2[2]};
  assign w_one     = (w_n_high == 2'd1);
  assign w_multi   = (w_n_high >= 2'd2);

  always_comb begin
    w_next   = r_state;
    w_latch  = 1'b0;
    w_db_inc = 1'b0;
    w_err    = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
    w_to     = 1'b0;
    w_to_inc = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        // Close-of-poll beats a coincident enable edge.
        if (r_over_q)       w_next = S_CLOSED;
        else if (w_en_rise) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (r_over_q) begin
          w_next = S_CLOSED;
        end else if (w_one) begin
          w_next  = S_DEBOUNCE;
          w_latch = 1'b1;
        end else begin
          // One error pulse per multi-press episode; lock drops on full release.
          if (w_multi && !r_err_lock) w_err = 1'b1;
`ifdef BALLOT_TIMEOUT_EN
          if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            w_next = S_IDLE;
            w_to   = 1'b1;
          end else begin
            w_to_inc = 1'b1;
          end
`endif
        end
      end
      S_DEBOUNCE: begin
        if (r_over_q) begin
          w_next = S_CLOSED;
        end else if (r_sync2 == r_sel) begin
          if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES)) w_next = S_COMMIT;
          else                                    w_db_inc = 1'b1;
        end else begin
          w_next = S_ARMED;
        end
      end
      S_COMMIT: begin
        // The vote always completes; a pending close follows it.
        w_next = r_over_q ? S_CLOSED : S_WAIT_RELEASE;
      end
      S_WAIT_RELEASE: begin
        if (r_over_q)            w_next = S_CLOSED;
        else if (r_sync2 == 3'b0) w_next = S_IDLE;
      end
      S_CLOSED: w_next = S_CLOSED;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_sync1    <= 3'b0;
      r_sync2    <= 3'b0;
      r_en_q     <= 1'b0;
      r_en_qq    <= 1'b0;
      r_over_q   <= 1'b0;
      r_sel      <= 3'b0;
      r_db_cnt   <= '0;
      r_err_lock <= 1'b0;
      r_vote     <= 3'b0;
      r_ack      <= 1'b0;
      r_ready    <= 1'b0;
      r_error    <= 1'b0;
      r_closed   <= 1'b0;
      r_voters   <= '0;
    end else begin
      r_state  <= w_next;
      r_sync1  <= {i_candidate_3, i_candidate_2, i_candidate_1};
      r_sync2  <= r_sync1;
      r_en_q   <= i_voter_enable;
      r_en_qq  <= r_en_q;
      r_over_q <= i_voting_over;

      if (w_latch) r_sel <= r_sync2;

      if (w_latch)       r_db_cnt <= '0;
      else if (w_db_inc) r_db_cnt <= r_db_cnt + DB_W'(1);

      if (w_err)                 r_err_lock <= 1'b1;
      else if (r_sync2 == 3'b0)  r_err_lock <= 1'b0;

      // Outputs are registered from the next state so they line up with it.
      r_vote   <= (w_next == S_COMMIT) ? r_sel : 3'b0;
      r_ack    <= (w_next == S_COMMIT);
      r_ready  <= (w_next == S_ARMED) || (w_next == S_DEBOUNCE);
      r_error  <= w_err;
      r_closed <= (w_next == S_CLOSED);
      if ((w_next == S_COMMIT) && (r_voters != {CNT_W{1'b1}}))
        r_voters <= r_voters + CNT_W'(1);
    end
  end

`ifdef BALLOT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      // Counts only while waiting in ARMED; any other cycle restarts it.
      if (w_to_inc) r_to_cnt <= r_to_cnt + TO_W'(1);
      else          r_to_cnt <= '0;
      r_timeout <= w_to;
    end
  end
  assign o_timeout = r_timeout;
`else
  assign o_timeout = 1'b0;
`endif

  assign o_vote_1 = r_vote[0];
  assign o_vote_2 = r_vote[1];
  assign o_vote_3 = r_vote[2];
  assign o_ack    = r_ack;
  assign o_ready  = r_ready;
  assign o_error  = r_error;
  assign o_closed = r_closed;
  assign o_voters = r_voters;

endmodule

// File: tb/tb_ballot_controller.sv
// Bench for ballot_controller: directed scenarios plus random stimulus, all
// checked every cycle against a behavioural ballot model, with literal checks
// on latency, pulse counts and saturation.
module tb_ballot_controller;

  localparam int DB   = 4;
  localparam int TO   = 16;
  localparam int CW   = 6;
  localparam int VMAX = (1 << CW) - 1;

  localparam int P_IDLE = 0, P_ARMED = 1, P_DEB = 2, P_COMMIT = 3, P_WAIT = 4, P_CLOSED = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [2:0]    btn = 3'b0;
  logic          over = 1'b0;
  logic          o_vote_1, o_vote_2, o_vote_3, o_ready, o_ack, o_error, o_timeout, o_closed;
  logic [CW-1:0] o_voters;

  ballot_controller #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .i_voter_enable(en),
    .i_candidate_1(btn[0]), .i_candidate_2(btn[1]), .i_candidate_3(btn[2]),
    .i_voting_over(over),
    .o_vote_1(o_vote_1), .o_vote_2(o_vote_2), .o_vote_3(o_vote_3),
    .o_ready(o_ready), .o_ack(o_ack), .o_error(o_error), .o_timeout(o_timeout),
    .o_closed(o_closed), .o_voters(o_voters)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cnt_v[3] = '{0, 0, 0};
  int v_cyc[3] = '{0, 0, 0};
  int cnt_err = 0;
  int cnt_to = 0;

  // Behavioural ballot model: phase of the ballot, what the voter's button
  // looked like two edges ago (synchronised view), and the expected outputs.
  int         m_ph = P_IDLE;
  logic [2:0] m_s1 = 3'b0, m_sy = 3'b0, m_pick = 3'b0;
  logic       m_en1 = 1'b0, m_en2 = 1'b0, m_ov1 = 1'b0, m_lock = 1'b0;
  int         m_run = 0, m_age = 0, m_voters = 0;
  logic [2:0] e_vote = 3'b0;
  logic       e_ack = 1'b0, e_err = 1'b0, e_to = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int  nh;
    logic rise;
    if (rst) begin
      m_ph = P_IDLE; m_s1 = 0; m_sy = 0; m_pick = 0; m_en1 = 0; m_en2 = 0;
      m_ov1 = 0; m_lock = 0; m_run = 0; m_age = 0; m_voters = 0;
      e_vote = 0; e_ack = 0; e_err = 0; e_to = 0;
      return;
    end
    rise = m_en1 && !m_en2;
    nh = int'(m_sy[0]) + int'(m_sy[1]) + int'(m_sy[2]);
    e_vote = 0; e_ack = 0; e_err = 0; e_to = 0;
    if (m_ph == P_CLOSED) begin
      // the poll is over: nothing moves until reset
    end else if (m_ph == P_COMMIT) begin
      m_ph = m_ov1 ? P_CLOSED : P_WAIT;
    end else if (m_ov1) begin
      m_ph = P_CLOSED;
    end else if (m_ph == P_IDLE) begin
      if (rise) begin m_ph = P_ARMED; m_age = 0; end
    end else if (m_ph == P_ARMED) begin
      if (nh == 1) begin
        m_pick = m_sy; m_run = 0; m_ph = P_DEB;
      end else begin
        if (nh >= 2 && !m_lock) begin e_err = 1; m_lock = 1; end
`ifdef BALLOT_TIMEOUT_EN
        m_age++;
        if (m_age == TO) begin m_ph = P_IDLE; e_to = 1; end
`endif
      end
    end else if (m_ph == P_DEB) begin
      if (m_sy == m_pick) begin
        if (m_run == DB) begin
          m_ph = P_COMMIT; e_vote = m_pick; e_ack = 1;
          if (m_voters < VMAX) m_voters++;
        end else m_run++;
      end else begin
        m_ph = P_ARMED; m_age = 0;
      end
    end else if (m_ph == P_WAIT) begin
      if (m_sy == 0) m_ph = P_IDLE;
    end
    if (m_sy == 0) m_lock = 0;
    m_sy = m_s1; m_s1 = btn; m_en2 = m_en1; m_en1 = en; m_ov1 = over;
  endtask

  // One clock: advance the model at the edge, compare just after it,
  // then return at the falling edge where stimulus is changed.
  task automatic cycle();
    @(posedge clk);
    cyc++;
    model_step();
    #1;
    chk("vote_1", int'(o_vote_1), int'(e_vote[0]));
    chk("vote_2", int'(o_vote_2), int'(e_vote[1]));
    chk("vote_3", int'(o_vote_3), int'(e_vote[2]));
    chk("ack", int'(o_ack), int'(e_ack));
    chk("error", int'(o_error), int'(e_err));
    chk("timeout", int'(o_timeout), int'(e_to));
    chk("ready", int'(o_ready), int'((m_ph == P_ARMED || m_ph == P_DEB) && !rst));
    chk("closed", int'(o_closed), int'(m_ph == P_CLOSED && !rst));
    chk("voters", int'(o_voters), m_voters);
    if (o_vote_1) begin cnt_v[0]++; v_cyc[0] = cyc; end
    if (o_vote_2) begin cnt_v[1]++; v_cyc[1] = cyc; end
    if (o_vote_3) begin cnt_v[2]++; v_cyc[2] = cyc; end
    if (o_error) cnt_err++;
    if (o_timeout) cnt_to++;
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic ballot(input int b);
    en = 0; cycles(1);
    en = 1; cycles(2);
    btn[b] = 1'b1; cycles(9);
    btn = 3'b0; cycles(4);
  endtask

  int base0, base1, base2, basee, baset, k, rdy_cnt, closed_age;

  initial begin
    // Reset state
    cycles(3);
    chk("reset_voters", int'(o_voters), 0);
    chk("reset_closed", int'(o_closed), 0);
    chk("reset_ready", int'(o_ready), 0);
    rst = 0; cycles(2);

    // 1: single held press of candidate 2 -> one vote at k+3+DB
    base1 = cnt_v[1];
    en = 1; cycles(2);
    btn[1] = 1'b1; k = cyc + 1; cycles(10);
    btn = 3'b0;
    chk("t1_vote2_count", cnt_v[1] - base1, 1);
    chk("t1_vote_latency", v_cyc[1] - k, 7);
    chk("t1_voters", int'(o_voters), 1);
    chk("t1_ready_low", int'(o_ready), 0);
    en = 0; cycles(4);

    // 2: bounce then a clean press of candidate 1
    base0 = cnt_v[0];
    en = 1; cycles(2);
    btn[0] = 1'b1; cycles(2); btn[0] = 1'b0; cycles(3);
    chk("t2_no_vote_on_bounce", cnt_v[0] - base0, 0);
    btn[0] = 1'b1; cycles(10); btn = 3'b0; cycles(4);
    chk("t2_vote1_count", cnt_v[0] - base0, 1);
    en = 0; cycles(2);

    // 3: candidates 1+3 together -> one error, then candidate 3 votes
    base0 = cnt_v[0]; base2 = cnt_v[2]; basee = cnt_err;
    en = 1; cycles(2);
    btn = 3'b101; cycles(3); btn = 3'b000; cycles(4);
    chk("t3_error_count", cnt_err - basee, 1);
    chk("t3_no_vote", cnt_v[0] - base0 + cnt_v[2] - base2, 0);
    btn[2] = 1'b1; cycles(10); btn = 3'b0; cycles(4);
    chk("t3_vote3_count", cnt_v[2] - base2, 1);
    en = 0; cycles(2);

    // 4: press while unarmed, then arm while still holding
    base0 = cnt_v[0];
    btn[0] = 1'b1; cycles(6);
    chk("t4_no_vote_unarmed", cnt_v[0] - base0, 0);
    en = 1; cycles(20); btn = 3'b0; cycles(4);
    chk("t4_one_vote", cnt_v[0] - base0, 1);
    chk("t4_voters", int'(o_voters), 4);
    en = 0; cycles(2);

    // 5: close mid-debounce; later activity ignored; reset reopens
    base0 = cnt_v[0]; base1 = cnt_v[1];
    en = 1; cycles(2);
    btn[0] = 1'b1; cycles(4);
    over = 1'b1; cycles(2);
    chk("t5_closed", int'(o_closed), 1);
    over = 1'b0; btn = 3'b0; en = 0; cycles(2);
    en = 1; cycles(2); btn[1] = 1'b1; cycles(10); btn = 3'b0; cycles(2);
    chk("t5_no_votes", cnt_v[0] - base0 + cnt_v[1] - base1, 0);
    chk("t5_still_closed", int'(o_closed), 1);
    chk("t5_voters_kept", int'(o_voters), 4);
    rst = 1'b1; #1;
    chk("t5_reset_closed", int'(o_closed), 0);
    chk("t5_reset_voters", int'(o_voters), 0);
    en = 0; cycles(2); rst = 1'b0; cycles(2);

    // Asynchronous reset during debounce discards the ballot
    base2 = cnt_v[2];
    en = 1; cycles(2);
    chk("ar_ready", int'(o_ready), 1);
    btn[2] = 1'b1; cycles(5);
    rst = 1'b1; #1;
    chk("ar_ready_cleared", int'(o_ready), 0);
    chk("ar_no_vote", int'(o_vote_3), 0);
    cycles(2); rst = 1'b0; btn = 3'b0; en = 0; cycles(12);
    chk("ar_vote3_count", cnt_v[2] - base2, 0);

`ifdef BALLOT_TIMEOUT_EN
    // Armed ballot with no press expires after TO armed cycles
    baset = cnt_to; rdy_cnt = 0;
    en = 1;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (o_ready) rdy_cnt++;
    end
    chk("to_ready_cycles", rdy_cnt, TO);
    chk("to_pulse_count", cnt_to - baset, 1);
    chk("to_ready_low", int'(o_ready), 0);
    en = 0; cycles(2);
`endif

    // Saturation: 70 committed ballots on a 6-bit counter
    rst = 1'b1; cycles(2); rst = 1'b0; cycles(1);
    for (int i = 0; i < 70; i++) ballot(int'($urandom_range(0, 2)));
    chk("sat_voters", int'(o_voters), VMAX);

    // Random stimulus against the model
    rst = 1'b1; cycles(2); rst = 1'b0; cycles(1);
    closed_age = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      for (int b = 0; b < 3; b++)
        if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
      over = ($urandom_range(0, 299) == 0);
      if (m_ph == P_CLOSED) closed_age++;
      else closed_age = 0;
      rst = (closed_age > 5) || ($urandom_range(0, 999) == 0);
      cycle();
    end
    rst = 1'b0; over = 1'b0; btn = 3'b0; en = 1'b0;
    cycles(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
